// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared widths, frame limits and FSM states for serializer/deserializer
//
// Holds the word width, the modulo field width, the minimum frame length and
// the receive FSM state type.
package ser_pkg;

    localparam int DATA_W        = 16;
    localparam int MOD_W         = 4;
    localparam int MIN_FRAME_LEN = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } ser_state_e;

endpackage

// File: rtl/deser_out_reg.sv
// rtl/deser_out_reg.sv - single-entry output holding register with valid/ready handshake
//
// Ports:
//   clk_i         : clock, rising edge
//   arstn_i       : asynchronous active-low reset
//   commit_i      : a finished frame is presented this cycle
//   commit_data_i : left-aligned frame word
//   commit_mod_i  : bit count of the frame (0 means full width)
//   rdy_i         : consumer accepts the held word when high with val_o
//   data_o        : held word
//   mod_o         : held bit count
//   val_o         : held word valid
//   overflow_o    : one-cycle pulse when a commit is dropped because the register is full
module deser_out_reg
    import ser_pkg::*;
(
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              commit_i,
    input  logic [DATA_W-1:0] commit_data_i,
    input  logic [MOD_W-1:0]  commit_mod_i,
    input  logic              rdy_i,
    output logic [DATA_W-1:0] data_o,
    output logic [MOD_W-1:0]  mod_o,
    output logic              val_o,
    output logic              overflow_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [MOD_W-1:0]  mod_q,  mod_d;
    logic              val_q,  val_d;
    logic              ovf_q,  ovf_d;

    always_comb begin
        data_d = data_q;
        mod_d  = mod_q;
        val_d  = val_q;
        ovf_d  = 1'b0;
        if (commit_i) begin
            // The slot is free if empty or being drained at this same edge.
            if (!val_q || rdy_i) begin
                data_d = commit_data_i;
                mod_d  = commit_mod_i;
                val_d  = 1'b1;
            end else begin
                ovf_d  = 1'b1;
            end
        end else if (val_q && rdy_i) begin
            val_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            data_q <= '0;
            mod_q  <= '0;
            val_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            mod_q  <= mod_d;
            val_q  <= val_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign mod_o      = mod_q;
    assign val_o      = val_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - MSB-first serial to 16-bit word deserializer with held output
//
// Optional feature macro: DESERIALIZER_MIN_LEN_EN (drop 1- and 2-bit frames, pulse err_o).
//
// Ports:
//   clk_i            : clock, rising edge
//   arstn_i          : asynchronous active-low reset
//   ser_data_i       : serial bit, MSB first
//   ser_data_val_i   : serial bit valid; a contiguous high run is one frame
//   deser_data_o     : assembled word, left-aligned, unused low bits 0
//   deser_mod_o      : bits in the word, 0 means 16
//   deser_data_val_o : output word valid, held until accepted
//   deser_rdy_i      : consumer accepts the word
//   busy_o           : a frame is being received
//   overflow_o       : pulse when a completed frame is dropped
//   err_o            : pulse when a short frame is dropped
module deserializer
    import ser_pkg::*;
(
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_mod_o,
    output logic              deser_data_val_o,
    input  logic              deser_rdy_i,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              err_o
);

    ser_state_e        state_q, state_d;
    logic [MOD_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] buf_q,   buf_d;

    logic              close;
    logic              commit;
    logic [DATA_W-1:0] close_data;
    logic [MOD_W-1:0]  close_mod;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        close      = 1'b0;
        close_data = buf_q;
        close_mod  = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ser_data_val_i) begin
                    // A new frame always starts from a clean buffer.
                    buf_d             = '0;
                    buf_d[DATA_W-1]   = ser_data_i;
                    cnt_d             = 4'd1;
                    state_d           = ST_RECV;
                end
            end
            ST_RECV: begin
                if (ser_data_val_i) begin
                    if (cnt_q == 4'(DATA_W - 1)) begin
                        // Sixteenth bit closes the frame in the same cycle;
                        // the count wraps to 0, which is also the mod encoding for 16.
                        close      = 1'b1;
                        close_data = {buf_q[DATA_W-1:1], ser_data_i};
                        close_mod  = '0;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        buf_d[4'(DATA_W - 1) - cnt_q] = ser_data_i;
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    close   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef DESERIALIZER_MIN_LEN_EN
    logic short_close;
    logic err_q, err_d;

    // Only a low-valid close can be short; a 16-bit close is always long enough.
    assign short_close = close && !ser_data_val_i && (cnt_q < 4'(MIN_FRAME_LEN));
    assign commit      = close && !short_close;
    assign err_d       = short_close;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign commit = close;
    assign err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign busy_o = (state_q == ST_RECV);

    deser_out_reg u_out_reg (
        .clk_i         (clk_i),
        .arstn_i       (arstn_i),
        .commit_i      (commit),
        .commit_data_i (close_data),
        .commit_mod_i  (close_mod),
        .rdy_i         (deser_rdy_i),
        .data_o        (deser_data_o),
        .mod_o         (deser_mod_o),
        .val_o         (deser_data_val_o),
        .overflow_o    (overflow_o)
    );

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all logic rising-edge.
REQ-002 SHALL have: arstn_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: ser_data_i  in  1  serial bit, MSB of the frame first.
REQ-004 SHALL have: ser_data_val_i  in  1  ser_data_i valid; a contiguous high run is one frame.
REQ-005 SHALL have: deser_data_o  out  16  assembled word, left-aligned, unused low bits 0.
REQ-006 SHALL have: deser_mod_o  out  4  bits in the word; 0 means 16.
REQ-007 SHALL have: deser_data_val_o  out  1  output word valid, held until accepted.
REQ-008 SHALL have: deser_rdy_i  in  1  consumer accepts the word when high with valid at a clock edge.
REQ-009 SHALL have: busy_o  out  1  high while a frame is being received (state RECV).
REQ-010 SHALL have: overflow_o  out  1  one-cycle pulse when a completed frame is dropped.
REQ-011 SHALL have: err_o  out  1  one-cycle pulse when a short frame is dropped (see REQ-024).

Function
REQ-012 SHALL implement FSM IDLE/RECV; IDLE with ser_data_val_i=1 -> RECV, bit count=1, bit stored at position 15.
REQ-013 In RECV with ser_data_val_i=1 and count<15, SHALL store the bit at position 15-count and increment count.
REQ-014 In RECV with ser_data_val_i=1 and count=15, SHALL close the frame including that bit (16 bits, mod 0) and return to IDLE.
REQ-015 In RECV with ser_data_val_i=0, SHALL close the frame with count bits (mod=count) and return to IDLE.
REQ-016 Closing SHALL commit to the single-entry output register at the same edge; deser_data_val_o is high from the cycle after the closing input cycle.
REQ-017 The cycle after a 16-bit close, ser_data_val_i=1 SHALL start a new frame; no idle gap is required.
REQ-018 deser_data_val_o, deser_data_o and deser_mod_o SHALL stay stable until deser_rdy_i=1 at a clock edge.
REQ-019 A commit at the same edge as an acceptance SHALL load the new word, and deser_data_val_o SHALL stay high.
REQ-020 A commit while the register is full and not accepted SHALL drop the new frame, keep the held word and pulse overflow_o.
REQ-021 ser_data_i SHALL be ignored when ser_data_val_i=0; the assembly buffer SHALL be cleared on each frame start.

Reset
REQ-022 arstn_i=0 SHALL immediately force state IDLE, count 0, output register empty, and all outputs 0.
REQ-023 Reset mid-frame SHALL discard the partial frame with no pulse on any output; the first valid bit after release starts a fresh frame.

Configuration
REQ-024 With DESERIALIZER_MIN_LEN_EN defined, frames of 1 or 2 bits SHALL NOT be committed and err_o SHALL pulse at the closing edge.
REQ-025 Without DESERIALIZER_MIN_LEN_EN, frames of 1-16 bits SHALL all be committed, and err_o SHALL remain present and tied 0.

Structure
REQ-026 Package ser_pkg SHALL hold DATA_W=16, MOD_W=4, MIN_FRAME_LEN=3 and the FSM state enum; serializer and deserializer share it.
REQ-027 Sub-module deser_out_reg SHALL implement the output holding register, valid/ready handshake and overflow detection.

Verification
REQ-028 0xA5C3 over 16 cycles, rdy=1 -> next cycle data=0xA5C3, mod=0, val high one cycle, busy low.
REQ-029 Bits 1,0,1,1,0 then val low -> data=0xB000, mod=5 the cycle after the first low-val cycle.
REQ-030 rdy=0; frame 0xFFFF then 5-bit 0x1234 prefix -> held 0xFFFF, overflow_o one pulse; rdy=1 -> 0xFFFF accepted, val low.
REQ-031 2-bit frame 1,0: macro on -> err_o pulse, no val; macro off -> data=0x8000, mod=2, err_o 0.
REQ-032 arstn_i low after 7 bits -> all outputs 0 at once; after release, 3-bit frame 1,1,1 -> data=0xE000, mod=3.
REQ-033 Held word plus rdy=1 at the same edge as a 16-bit close of 0x0F0F -> val stays high, data=0x0F0F, no overflow.
